// File: rtl/sd_pkg.sv
// Shared constants and encodings for the SD card initialisation sequencer.
// Command words are {index[5:0], arg[31:0]}.
package sd_pkg;

   localparam logic [5:0] CMD0_IDX   = 6'd0;
   localparam logic [5:0] CMD8_IDX   = 6'd8;
   localparam logic [5:0] CMD55_IDX  = 6'd55;
   localparam logic [5:0] ACMD41_IDX = 6'd41;
   localparam logic [5:0] CMD2_IDX   = 6'd2;
   localparam logic [5:0] CMD3_IDX   = 6'd3;

   localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
   localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
   localparam logic [11:0] CMD8_ECHO  = 12'h1AA;

   typedef enum logic [2:0] {
      STEP_CMD0,
      STEP_CMD8,
      STEP_CMD55,
      STEP_ACMD41,
      STEP_CMD2,
      STEP_CMD3
   } step_t;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_ECHO     = 3'd1,
      ERR_RESP_TMO = 3'd2,
      ERR_ACMD41   = 3'd3,
      ERR_FIN_TMO  = 3'd4
   } err_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWR_WAIT,
      ST_ISSUE,
      ST_WAIT_FIN,
      ST_WAIT_RESP,
      ST_CHECK,
      ST_GAP,
      ST_DONE,
      ST_ERROR
   } state_t;

   function automatic logic [37:0] cmd_of(input step_t s);
      logic [37:0] c;
      case (s)
         STEP_CMD0:   c = {CMD0_IDX, 32'h0};
         STEP_CMD8:   c = {CMD8_IDX, CMD8_ARG};
         STEP_CMD55:  c = {CMD55_IDX, 32'h0};
         STEP_ACMD41: c = {ACMD41_IDX, ACMD41_ARG};
         STEP_CMD2:   c = {CMD2_IDX, 32'h0};
         STEP_CMD3:   c = {CMD3_IDX, 32'h0};
         default:     c = {CMD0_IDX, 32'h0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sd_timeout_cnt.sv
// Saturating cycle counter; expired is high during the limit-th
// enabled cycle after a clear, so a state can leave after exactly limit cycles.
module sd_timeout_cnt #(
   parameter int W = 8
) (
   input  logic         ex_clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt;
   logic [W:0]   nxt;

   assign nxt = {1'b0, cnt} + (W+1)'(1);
   assign expired = enable && (nxt >= {1'b0, limit});

   always_ff @(posedge ex_clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != limit)) begin
         cnt <= nxt[W-1:0];
      end
   end

endmodule

// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 until ready,
// then CMD2 and CMD3; captures the RCA and reports done or an error code.
module sd_init_seq
   import sd_pkg::*;
#(
   parameter int PWRUP_CYCLES = 200,
   parameter int RESP_TIMEOUT = 4096,
   parameter int ACMD41_MAX   = 1000,
   parameter int RETRY_GAP    = 1024
) (
   input  logic        ex_clk,
   input  logic        reset,
   input  logic        start,
   output logic        send_en,
   output logic [37:0] cmd_content,
   input  logic        finished,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   output logic        busy,
   output logic        init_done,
   output logic        init_err,
   output logic [2:0]  err_code,
   output logic [15:0] rca
);

   localparam int PW_W = $clog2(PWRUP_CYCLES) + 1;
   localparam int TO_W = $clog2(RESP_TIMEOUT) + 1;
   localparam int AC_W = $clog2(ACMD41_MAX) + 1;
   localparam int GP_W = $clog2(RETRY_GAP) + 1;

   state_t          st;
   step_t           step;
   logic [AC_W-1:0] acnt;
   logic [AC_W-1:0] acnt_inc;
   logic            pend;
   logic [31:0]     pend_data;
   logic [31:0]     rdata;
   logic            echo_ok;

   logic pwr_exp, wait_exp, gap_exp;
   logic pwr_en, wait_en, gap_en;
   logic wait_clr;

   assign pwr_en   = (st == ST_PWR_WAIT);
   assign gap_en   = (st == ST_GAP);
   assign wait_en  = (st == ST_WAIT_FIN) || (st == ST_WAIT_RESP);
   // The response wait restarts from zero when finished arrives.
   assign wait_clr = !wait_en || ((st == ST_WAIT_FIN) && finished);

   assign acnt_inc = (acnt == AC_W'(ACMD41_MAX)) ? acnt : acnt + 1'b1;
   assign echo_ok  = (rdata[15:0] & 16'h0FFF) == {4'h0, CMD8_ECHO};

   sd_timeout_cnt #(.W(PW_W)) u_pwr_tmr (
      .ex_clk  (ex_clk),
      .reset   (reset),
      .clear   (!pwr_en),
      .enable  (pwr_en),
      .limit   (PW_W'(PWRUP_CYCLES)),
      .expired (pwr_exp)
   );

   sd_timeout_cnt #(.W(TO_W)) u_wait_tmr (
      .ex_clk  (ex_clk),
      .reset   (reset),
      .clear   (wait_clr),
      .enable  (wait_en),
      .limit   (TO_W'(RESP_TIMEOUT)),
      .expired (wait_exp)
   );

   sd_timeout_cnt #(.W(GP_W)) u_gap_tmr (
      .ex_clk  (ex_clk),
      .reset   (reset),
      .clear   (!gap_en),
      .enable  (gap_en),
      .limit   (GP_W'(RETRY_GAP)),
      .expired (gap_exp)
   );

   always_ff @(posedge ex_clk or posedge reset) begin
      if (reset) begin
         st          <= ST_IDLE;
         step        <= STEP_CMD0;
         send_en     <= 1'b0;
         cmd_content <= '0;
         busy        <= 1'b0;
         init_done   <= 1'b0;
         init_err    <= 1'b0;
         err_code    <= ERR_NONE;
         rca         <= '0;
         acnt        <= '0;
         pend        <= 1'b0;
         pend_data   <= '0;
         rdata       <= '0;
      end else begin
         send_en <= 1'b0;
         case (st)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  st        <= ST_PWR_WAIT;
                  step      <= STEP_CMD0;
                  busy      <= 1'b1;
                  init_done <= 1'b0;
                  init_err  <= 1'b0;
                  err_code  <= ERR_NONE;
                  rca       <= '0;
                  acnt      <= '0;
               end
            end
            ST_PWR_WAIT: begin
               if (pwr_exp) st <= ST_ISSUE;
            end
            ST_ISSUE: begin
               send_en     <= 1'b1;
               cmd_content <= cmd_of(step);
               pend        <= 1'b0;
               st          <= ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
               if (finished) begin
                  pend <= 1'b0;
                  if (step == STEP_CMD0) begin
                     step <= STEP_CMD8;
                     st   <= ST_ISSUE;
                  end else if (resp_valid) begin
                     rdata <= resp_data;
                     st    <= ST_CHECK;
                  end else if (pend) begin
                     rdata <= pend_data;
                     st    <= ST_CHECK;
                  end else begin
                     st <= ST_WAIT_RESP;
                  end
               end else if (wait_exp) begin
                  st       <= ST_ERROR;
                  busy     <= 1'b0;
                  init_err <= 1'b1;
                  err_code <= ERR_FIN_TMO;
               end else if (resp_valid) begin
                  // Response overtook the send-complete pulse.
                  pend      <= 1'b1;
                  pend_data <= resp_data;
               end
            end
            ST_WAIT_RESP: begin
               if (resp_valid) begin
                  rdata <= resp_data;
                  st    <= ST_CHECK;
               end else if (wait_exp) begin
                  st       <= ST_ERROR;
                  busy     <= 1'b0;
                  init_err <= 1'b1;
                  err_code <= ERR_RESP_TMO;
               end
            end
            ST_CHECK: begin
               st <= ST_ISSUE;
               case (step)
                  STEP_CMD8: begin
                     if (echo_ok) begin
                        step <= STEP_CMD55;
                     end else begin
                        st       <= ST_ERROR;
                        busy     <= 1'b0;
                        init_err <= 1'b1;
                        err_code <= ERR_ECHO;
                     end
                  end
                  STEP_CMD55: step <= STEP_ACMD41;
                  STEP_ACMD41: begin
                     if (rdata[31]) begin
                        step <= STEP_CMD2;
                     end else begin
                        acnt <= acnt_inc;
                        if (acnt_inc == AC_W'(ACMD41_MAX)) begin
                           st       <= ST_ERROR;
                           busy     <= 1'b0;
                           init_err <= 1'b1;
                           err_code <= ERR_ACMD41;
                        end else begin
                           st <= ST_GAP;
                        end
                     end
                  end
                  STEP_CMD2: step <= STEP_CMD3;
                  STEP_CMD3: begin
                     rca       <= rdata[31:16];
                     st        <= ST_DONE;
                     busy      <= 1'b0;
                     init_done <= 1'b1;
                  end
                  default: step <= STEP_CMD0;
               endcase
            end
            ST_GAP: begin
               if (gap_exp) begin
                  step <= STEP_CMD55;
                  st   <= ST_ISSUE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
